// File: rtl/reg_port_if.sv
// Requester-side bus of the register-port arbiter.
//   master : requester view (drives requests, receives ready/response)
//   slave  : arbiter view
//   req_valid/req_we : per-port request and direction (1 = write)
//   req_addr/req_wdata : packed per-port fields, port i at [i*W +: W]
//   req_ready/rsp_valid : one-hot 1-cycle pulses back to the requesters
//   rsp_rdata : shared read data, held until the next read completes
interface reg_port_if #(
    parameter int unsigned NUM_M_PORT   = 3,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned LB_REG_DEPTH = 8
);
    logic [NUM_M_PORT-1:0]              req_valid;
    logic [NUM_M_PORT-1:0]              req_we;
    logic [NUM_M_PORT*LB_REG_DEPTH-1:0] req_addr;
    logic [NUM_M_PORT*DATA_WIDTH-1:0]   req_wdata;
    logic [NUM_M_PORT-1:0]              req_ready;
    logic [NUM_M_PORT-1:0]              rsp_valid;
    logic [DATA_WIDTH-1:0]              rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter sharing a single-ported register memory between
// NUM_M_PORT requesters. One transaction in flight at a time; the winning
// command is registered onto the memory port and read data is returned to
// the granted requester.
//   clk, rst      : clock, asynchronous active-high reset
//   bus (slave)   : requester handshake bus (see reg_port_if)
//   o_mem_we/re   : memory write/read strobes, high only in the issue cycle
//   o_mem_addr    : memory address, holds its last value outside issue
//   o_mem_wdata   : memory write data, holds its last value outside issue
//   i_mem_rdata   : memory read data, valid RD_LATENCY cycles after o_mem_re
module reg_port_arbiter #(
    parameter int unsigned NUM_M_PORT   = 3,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned REG_DEPTH    = 256,
    parameter int unsigned RD_LATENCY   = 1,
    localparam int unsigned LB_REG_DEPTH = $clog2(REG_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    reg_port_if.slave               bus,
    output logic                    o_mem_we,
    output logic                    o_mem_re,
    output logic [LB_REG_DEPTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);
    localparam int unsigned GW = $clog2(NUM_M_PORT);
    localparam int unsigned CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]              r_state;
    logic [GW-1:0]           r_grant;
    logic [GW-1:0]           r_last;
    logic                    r_we;
    logic [CW-1:0]           r_cnt;
    logic                    r_mem_we;
    logic                    r_mem_re;
    logic [LB_REG_DEPTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic [NUM_M_PORT-1:0]   r_req_ready;
    logic [NUM_M_PORT-1:0]   r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;

    logic [1:0]              w_state_nxt;
    logic [GW-1:0]           w_grant_nxt;
    logic [GW-1:0]           w_last_nxt;
    logic                    w_we_nxt;
    logic [CW-1:0]           w_cnt_nxt;
    logic                    w_mem_we_nxt;
    logic                    w_mem_re_nxt;
    logic [LB_REG_DEPTH-1:0] w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0]   w_mem_wdata_nxt;
    logic [NUM_M_PORT-1:0]   w_req_ready_nxt;
    logic [NUM_M_PORT-1:0]   w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   w_rsp_rdata_nxt;

    logic                    w_found;
    logic [GW-1:0]           w_win;
    logic [GW-1:0]           w_cand;

    logic [LB_REG_DEPTH-1:0] w_addr_arr  [NUM_M_PORT];
    logic [DATA_WIDTH-1:0]   w_wdata_arr [NUM_M_PORT];

    // Unpack the per-port address/data fields
    for (genvar p = 0; p < NUM_M_PORT; p++) begin : g_unpack
        assign w_addr_arr[p]  = bus.req_addr[p*LB_REG_DEPTH +: LB_REG_DEPTH];
        assign w_wdata_arr[p] = bus.req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin pick: first requester after the last granted port
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int unsigned off = 1; off <= NUM_M_PORT; off++) begin
            w_cand = GW'((32'(r_last) + off) % NUM_M_PORT);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Next state; outputs are computed one cycle ahead so they register
    // into place in the same cycle as the state they belong to
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_last_nxt      = r_last;
        w_we_nxt        = r_we;
        w_cnt_nxt       = r_cnt;
        w_mem_we_nxt    = 1'b0;
        w_mem_re_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_req_ready_nxt = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_rdata_nxt = r_rsp_rdata;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = S_ISSUE;
                    w_grant_nxt     = w_win;
                    w_we_nxt        = bus.req_we[w_win];
                    w_mem_we_nxt    = bus.req_we[w_win];
                    w_mem_re_nxt    = !bus.req_we[w_win];
                    w_mem_addr_nxt  = w_addr_arr[w_win];
                    w_mem_wdata_nxt = w_wdata_arr[w_win];
                    w_req_ready_nxt = NUM_M_PORT'(1) << w_win;
                end
            end
            S_ISSUE: begin
                w_last_nxt = r_grant;
                if (r_we) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CW'(RD_LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_rdata_nxt = i_mem_rdata;
                    w_rsp_valid_nxt = NUM_M_PORT'(1) << r_grant;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_last      <= GW'(NUM_M_PORT - 1);
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_last      <= w_last_nxt;
            r_we        <= w_we_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_re    <= w_mem_re_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign o_mem_we      = r_mem_we;
    assign o_mem_re      = r_mem_re;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
endmodule
